// File: rtl/sht40_pkg.sv
// Shared types and constants for the SHT40 raw-word to fixed-point converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sht40_pkg;

  // Converter sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Default conversion constants, all in hundredths of the output unit
  localparam int DEF_T_SCALE   = 17500;
  localparam int DEF_T_OFFSET  = -4500;
  localparam int DEF_RH_SCALE  = 12500;
  localparam int DEF_RH_OFFSET = -600;

  // Physical humidity range used when clipping is enabled
  localparam int RH_MIN = 0;
  localparam int RH_MAX = 10000;

  // One multiplier bit is consumed per cycle
  localparam int MUL_CYCLES = 16;

  // Half an LSB of the >>16 result, for round-to-nearest
  localparam logic [31:0] ROUND_CONST = 32'd32768;

  // Clip a signed humidity result into RH_MIN..RH_MAX
  function automatic logic [15:0] sat_rh(input logic signed [16:0] v);
    logic [15:0] r;
    if (v < 17'(RH_MIN)) begin
      r = 16'(RH_MIN);
    end else if (v > 17'(RH_MAX)) begin
      r = 16'(RH_MAX);
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sht40_shift_mul.sv
// 16x15 unsigned LSB-first shift-add multiplier with a 31-bit product.
// Latency: i_start loads operands; o_done pulses on the 16th following cycle, product valid after it.
// Backpressure: none; i_start while busy restarts with the new operands.
module sht40_shift_mul
  import sht40_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [14:0] i_mcand,
  input  logic [15:0] i_mplier,
  output logic        o_done,
  output logic [30:0] o_product
);

  logic        r_active;
  logic [3:0]  r_cnt;
  logic [30:0] r_mcand;
  logic [15:0] r_mplier;
  logic [30:0] r_acc;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= 4'd0;
      r_mcand  <= 31'd0;
      r_mplier <= 16'd0;
      r_acc    <= 31'd0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= 4'd0;
      r_mcand  <= {16'd0, i_mcand};
      r_mplier <= i_mplier;
      r_acc    <= 31'd0;
    end else if (r_active) begin
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 31'd0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 4'd1;
      if (r_cnt == 4'(MUL_CYCLES - 1)) begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_done    = r_active && (r_cnt == 4'(MUL_CYCLES - 1));
  assign o_product = r_acc;

endmodule

// File: rtl/sht40_unit_convert.sv
// Converts latched SHT40 raw temperature/humidity words to signed centi-degC / centi-%RH.
// Latency: valid pulses 18 cycles after ready is first sampled high (idle); temperature wins ties.
// Backpressure: none; new ready edges are held as pending work. SHT40_RH_CLAMP_EN clips humidity to 0..10000.
module sht40_unit_convert
  import sht40_pkg::*;
#(
  parameter int T_SCALE   = DEF_T_SCALE,
  parameter int T_OFFSET  = DEF_T_OFFSET,
  parameter int RH_SCALE  = DEF_RH_SCALE,
  parameter int RH_OFFSET = DEF_RH_OFFSET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temp_raw,
  input  logic [15:0] rh_raw,
  input  logic        temp_ready,
  input  logic        rh_ready,
  output logic [15:0] temp_centi,
  output logic [15:0] rh_centi,
  output logic        temp_valid,
  output logic        rh_valid,
  output logic        busy
);

  state_t r_state, w_state_nxt;

  logic        r_t_prev, r_rh_prev;
  logic        r_t_pend, r_rh_pend;
  logic [15:0] r_t_hold, r_rh_hold;
  logic        r_sel_rh;
  logic [15:0] r_temp_centi, r_rh_centi;
  logic        r_temp_valid, r_rh_valid;

  logic        w_t_rise, w_rh_rise;
  logic        w_start, w_pick_rh, w_clr_t, w_clr_rh, w_fin;
  logic [14:0] w_mcand;
  logic [15:0] w_mplier;
  logic        w_mul_done;
  logic [30:0] w_product;
  logic [31:0] w_rnd;
  logic signed [16:0] w_scaled, w_off, w_res17;
  logic [15:0] w_rh_res;

  assign w_t_rise  = temp_ready & ~r_t_prev;
  assign w_rh_rise = rh_ready & ~r_rh_prev;

  // Edge history, raw-word holds and pending flags; a fresh edge beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_prev  <= 1'b0;
      r_rh_prev <= 1'b0;
      r_t_pend  <= 1'b0;
      r_rh_pend <= 1'b0;
      r_t_hold  <= 16'd0;
      r_rh_hold <= 16'd0;
    end else begin
      r_t_prev  <= temp_ready;
      r_rh_prev <= rh_ready;
      if (w_t_rise) begin
        r_t_hold <= temp_raw;
        r_t_pend <= 1'b1;
      end else if (w_clr_t) begin
        r_t_pend <= 1'b0;
      end
      if (w_rh_rise) begin
        r_rh_hold <= rh_raw;
        r_rh_pend <= 1'b1;
      end else if (w_clr_rh) begin
        r_rh_pend <= 1'b0;
      end
    end
  end

  // State register plus the channel being converted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel_rh <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel_rh <= w_pick_rh;
    end
  end

  // Next-state and control: pick a pending channel in IDLE, wait out the multiply, finish in one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_pick_rh   = r_sel_rh;
    w_clr_t     = 1'b0;
    w_clr_rh    = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_t_pend) begin
          w_start     = 1'b1;
          w_pick_rh   = 1'b0;
          w_clr_t     = 1'b1;
          w_state_nxt = MUL;
        end else if (r_rh_pend) begin
          w_start     = 1'b1;
          w_pick_rh   = 1'b1;
          w_clr_rh    = 1'b1;
          w_state_nxt = MUL;
        end
      end
      MUL: begin
        if (w_mul_done) begin
          w_state_nxt = FIN;
        end
      end
      FIN: begin
        w_fin       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_mcand  = w_pick_rh ? 15'(RH_SCALE) : 15'(T_SCALE);
  assign w_mplier = w_pick_rh ? r_rh_hold : r_t_hold;

  sht40_shift_mul u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_mcand   (w_mcand),
    .i_mplier  (w_mplier),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // Round the 16-bit fractional product, then apply the channel offset in 17-bit signed
  assign w_rnd    = {1'b0, w_product} + ROUND_CONST;
  assign w_scaled = 17'(w_rnd >> 16);
  assign w_off    = r_sel_rh ? 17'(RH_OFFSET) : 17'(T_OFFSET);
  assign w_res17  = w_scaled + w_off;

`ifdef SHT40_RH_CLAMP_EN
  assign w_rh_res = sat_rh(w_res17);
`else
  assign w_rh_res = 16'(w_res17);
`endif

  // Register the finished result into its channel and pulse that channel's valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_temp_centi <= 16'd0;
      r_rh_centi   <= 16'd0;
      r_temp_valid <= 1'b0;
      r_rh_valid   <= 1'b0;
    end else begin
      r_temp_valid <= w_fin & ~r_sel_rh;
      r_rh_valid   <= w_fin & r_sel_rh;
      if (w_fin && !r_sel_rh) begin
        r_temp_centi <= 16'(w_res17);
      end
      if (w_fin && r_sel_rh) begin
        r_rh_centi <= w_rh_res;
      end
    end
  end

  assign temp_centi = r_temp_centi;
  assign rh_centi   = r_rh_centi;
  assign temp_valid = r_temp_valid;
  assign rh_valid   = r_rh_valid;
  assign busy       = (r_state == MUL) || (r_state == FIN);

endmodule

// File: tb/tb_sht40_unit_convert.sv
// Self-checking bench for sht40_unit_convert against an arithmetic reference model.
module tb_sht40_unit_convert;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] temp_raw = 16'd0;
  logic [15:0] rh_raw = 16'd0;
  logic        temp_ready = 1'b0;
  logic        rh_ready = 1'b0;
  logic [15:0] temp_centi, rh_centi;
  logic        temp_valid, rh_valid, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sht40_unit_convert dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .temp_raw   (temp_raw),
    .rh_raw     (rh_raw),
    .temp_ready (temp_ready),
    .rh_ready   (rh_ready),
    .temp_centi (temp_centi),
    .rh_centi   (rh_centi),
    .temp_valid (temp_valid),
    .rh_valid   (rh_valid),
    .busy       (busy)
  );

  // Rounded raw*scale/65536 plus offset, optionally clipped for humidity
  function automatic logic [15:0] model(input bit is_rh, input logic [15:0] raw);
    longint scale;
    longint off;
    longint v;
    scale = is_rh ? 64'sd12500 : 64'sd17500;
    off   = is_rh ? -64'sd600 : -64'sd4500;
    v = (longint'(raw) * scale + 32768) / 65536 + off;
`ifdef SHT40_RH_CLAMP_EN
    if (is_rh) begin
      if (v < 0) v = 0;
      if (v > 10000) v = 10000;
    end
`endif
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated conversion: checks latency, value and pulse width, then drops ready
  task automatic conv(input bit is_rh, input logic [15:0] raw, input string tag);
    int k;
    bit seen;
    logic [15:0] got;
    logic [15:0] exp;
    exp = model(is_rh, raw);
    if (is_rh) begin rh_raw = raw; rh_ready = 1'b1; end
    else begin temp_raw = raw; temp_ready = 1'b1; end
    seen = 1'b0;
    k = -1;
    got = 16'd0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((is_rh ? rh_valid : temp_valid) === 1'b1) begin
        seen = 1'b1;
        k = i;
        got = is_rh ? rh_centi : temp_centi;
        break;
      end
    end
    n_vec++;
    if (!seen || k != 18) begin
      n_err++;
      $display("FAIL %s latency: got %0d (seen=%0d), expected 18", tag, k, seen);
    end
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s value: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
    tick();
    n_vec++;
    if ((is_rh ? rh_valid : temp_valid) !== 1'b0) begin
      n_err++;
      $display("FAIL %s pulse width: valid still high one cycle later", tag);
    end
    temp_ready = 1'b0;
    rh_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({temp_centi, rh_centi, temp_valid, rh_valid, busy} !== 35'd0) begin
      n_err++;
      $display("FAIL reset outputs: got t=%h rh=%h tv=%b rv=%b busy=%b, expected all 0",
               temp_centi, rh_centi, temp_valid, rh_valid, busy);
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b0 || temp_valid !== 1'b0 || rh_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle after reset: busy=%b tv=%b rv=%b, expected 0", busy, temp_valid, rh_valid);
    end
  endtask

  task automatic test_temp();
    conv(1'b0, 16'h0000, "temp_0000");
    n_vec++;
    if (temp_centi !== 16'hEE6C) begin
      n_err++;
      $display("FAIL temp_0000 literal: got %h, expected ee6c", temp_centi);
    end
    conv(1'b0, 16'hFFFF, "temp_ffff");
    n_vec++;
    if (temp_centi !== 16'd13000) begin
      n_err++;
      $display("FAIL temp_ffff literal: got %0d, expected 13000", $signed(temp_centi));
    end
    conv(1'b0, 16'h6666, "temp_6666");
  endtask

  task automatic test_rh();
    conv(1'b1, 16'h8000, "rh_8000");
    n_vec++;
    if (rh_centi !== 16'd5650) begin
      n_err++;
      $display("FAIL rh_8000 literal: got %0d, expected 5650", $signed(rh_centi));
    end
    conv(1'b1, 16'h0000, "rh_0000");
    conv(1'b1, 16'hFFFF, "rh_ffff");
  endtask

  task automatic test_simultaneous();
    int tv_at, rv_at, busy_cnt;
    logic [15:0] tv_val, rv_val;
    logic busy_gap;
    tv_at = -1; rv_at = -1; busy_cnt = 0; busy_gap = 1'b1;
    tv_val = 16'd0; rv_val = 16'd0;
    temp_raw = 16'h6666; rh_raw = 16'h8000;
    temp_ready = 1'b1; rh_ready = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (temp_valid === 1'b1 && tv_at < 0) begin tv_at = i; tv_val = temp_centi; end
      if (rh_valid === 1'b1 && rv_at < 0) begin rv_at = i; rv_val = rh_centi; end
      if (i <= 36 && busy === 1'b1) busy_cnt++;
      if (i == 18) busy_gap = busy;
    end
    n_vec++;
    if (tv_at != 18) begin n_err++; $display("FAIL sim temp latency: got %0d, expected 18", tv_at); end
    n_vec++;
    if (rv_at != 36) begin n_err++; $display("FAIL sim rh latency: got %0d, expected 36", rv_at); end
    n_vec++;
    if (tv_val !== model(1'b0, 16'h6666)) begin
      n_err++; $display("FAIL sim temp value: got %0d, expected 2500", $signed(tv_val));
    end
    n_vec++;
    if (rv_val !== model(1'b1, 16'h8000)) begin
      n_err++; $display("FAIL sim rh value: got %0d, expected 5650", $signed(rv_val));
    end
    n_vec++;
    if (busy_cnt != 34 || busy_gap !== 1'b0) begin
      n_err++; $display("FAIL sim busy: got %0d high cycles gap=%b, expected 34 and 0", busy_cnt, busy_gap);
    end
    temp_ready = 1'b0; rh_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_hold();
    logic [15:0] a;
    int at;
    logic [15:0] v;
    a = 16'($urandom);
    at = -1; v = 16'd0;
    temp_raw = a; temp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 3) temp_raw = ~a;
      if (temp_valid === 1'b1 && at < 0) begin at = i; v = temp_centi; end
    end
    n_vec++;
    if (at != 18 || v !== model(1'b0, a)) begin
      n_err++;
      $display("FAIL hold: got %0d at %0d, expected %0d at 18", $signed(v), at, $signed(model(1'b0, a)));
    end
    temp_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_retrigger();
    logic [15:0] a, b;
    int n_pulse, at1, at2;
    logic [15:0] v1, v2;
    a = 16'($urandom); b = 16'($urandom);
    n_pulse = 0; at1 = -1; at2 = -1; v1 = 16'd0; v2 = 16'd0;
    temp_raw = a; temp_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 5) temp_ready = 1'b0;
      if (i == 7) begin temp_raw = b; temp_ready = 1'b1; end
      if (temp_valid === 1'b1) begin
        n_pulse++;
        if (at1 < 0) begin at1 = i; v1 = temp_centi; end
        else if (at2 < 0) begin at2 = i; v2 = temp_centi; end
      end
    end
    n_vec++;
    if (n_pulse != 2 || at1 != 18 || at2 != 36) begin
      n_err++;
      $display("FAIL retrigger timing: got %0d pulses at %0d/%0d, expected 2 at 18/36", n_pulse, at1, at2);
    end
    n_vec++;
    if (v1 !== model(1'b0, a) || v2 !== model(1'b0, b)) begin
      n_err++;
      $display("FAIL retrigger values: got %0d/%0d, expected %0d/%0d", $signed(v1), $signed(v2),
               $signed(model(1'b0, a)), $signed(model(1'b0, b)));
    end
    temp_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int n_pulse;
    n_pulse = 0;
    temp_raw = 16'($urandom); temp_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    temp_ready = 1'b0;
    #1;
    n_vec++;
    if ({temp_centi, rh_centi, temp_valid, rh_valid, busy} !== 35'd0) begin
      n_err++;
      $display("FAIL mid reset outputs: got t=%h rh=%h tv=%b rv=%b busy=%b, expected all 0",
               temp_centi, rh_centi, temp_valid, rh_valid, busy);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (temp_valid === 1'b1 || rh_valid === 1'b1 || busy === 1'b1) n_pulse++;
    end
    n_vec++;
    if (n_pulse != 0) begin
      n_err++;
      $display("FAIL mid reset abort: got %0d active cycles after release, expected 0", n_pulse);
    end
  endtask

  task automatic test_ready_through_reset();
    logic [15:0] x;
    int n_pulse, at;
    logic [15:0] v;
    x = 16'($urandom);
    n_pulse = 0; at = -1; v = 16'd0;
    rst_n = 1'b0;
    temp_raw = x; temp_ready = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (temp_valid === 1'b1) begin
        n_pulse++;
        if (at < 0) begin at = i; v = temp_centi; end
      end
    end
    n_vec++;
    if (n_pulse != 1 || at != 18) begin
      n_err++;
      $display("FAIL ready through reset: got %0d pulses first at %0d, expected 1 at 18", n_pulse, at);
    end
    n_vec++;
    if (v !== model(1'b0, x)) begin
      n_err++;
      $display("FAIL ready through reset value: got %0d, expected %0d", $signed(v), $signed(model(1'b0, x)));
    end
    temp_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bit is_rh;
      logic [15:0] raw;
      is_rh = 1'($urandom_range(0, 1));
      raw = 16'($urandom);
      conv(is_rh, raw, $sformatf("rand%0d_%s_%h", n, is_rh ? "rh" : "t", raw));
    end
  endtask

  initial begin
    test_reset();
    test_temp();
    test_rh();
    test_simultaneous();
    test_hold();
    test_retrigger();
    test_reset_mid();
    test_ready_through_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sht40_unit_convert.md
Name: sht40_unit_convert

Overview:
- Downstream consumer of the SHT40 CRC/assembly stage. Takes its 16-bit raw temperature/humidity words and their ready levels.
- Converts each raw word to signed fixed-point hundredths: centi-degC and centi-%RH.
- Uses one shared 16-cycle shift-add multiplier.
- Presents results with single-cycle valid pulses to the display/UART logic.

Parameters:
- T_SCALE, 17500, temperature span in centi-degC (datasheet 175 degC).
- T_OFFSET, -4500, temperature offset in centi-degC.
- RH_SCALE, 12500, humidity span in centi-%RH.
- RH_OFFSET, -600, humidity offset in centi-%RH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- temp_raw  in  16  raw temperature word from upstream
- rh_raw  in  16  raw humidity word from upstream
- temp_ready  in  1  upstream level; high once temperature CRC passed
- rh_ready  in  1  upstream level; high once humidity CRC passed
- temp_centi  out  16  signed centi-degC result
- rh_centi  out  16  signed centi-%RH result
- temp_valid  out  1  one-cycle pulse; temp_centi updated
- rh_valid  out  1  one-cycle pulse; rh_centi updated
- busy  out  1  high while a conversion is in MUL or FIN

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset: all outputs 0; FSM to IDLE; pending flags 0; edge-detect history 0. A ready level already high when reset releases counts as a rising edge and triggers a conversion.
- Edge capture, every cycle:
  - Rising edge on temp_ready latches temp_raw into t_hold and sets t_pend.
  - rh_ready does the same into rh_hold / rh_pend.
  - Holds make results immune to upstream overwriting raw words during the next read.
- New edge on a channel whose pend is set: hold overwritten, latest wins, still one conversion.
- New edge on the channel currently converting: sets pend; that channel converts again afterwards.
- FSM states:
  - IDLE: if t_pend, select temperature (priority); else if rh_pend, select humidity. Load multiplicand = scale, multiplier = hold; clear that pend; go MUL.
  - MUL: 16 cycles, LSB-first shift-add; 31-bit unsigned accumulator.
  - FIN: result = ((acc + 32768) >> 16) + offset, computed as 17-bit signed and truncated to 16. Register into the channel output, pulse its valid, return to IDLE.
- Latency: valid asserts 18 cycles after the clock edge at which ready is first sampled high, when the FSM is idle.
- Simultaneous edges: temperature first. Humidity valid follows exactly 18 cycles after temp_valid (IDLE reload cycle included).
- busy is high in MUL and FIN only.
- Reset mid-conversion aborts immediately; no valid pulse; pending work is discarded.

Optional Feature:
- Macro: SHT40_RH_CLAMP_EN.
- Defined: rh_centi saturates to 0..10000 in FIN (datasheet clip).
- Undefined: rh_centi is the raw signed result (range -600..11900).
- Temperature is never clamped.

Decomposition:
- Package sht40_pkg holds:
  - FSM state enum (IDLE, MUL, FIN);
  - default scale/offset constants;
  - RH_MIN=0, RH_MAX=10000;
  - MUL_CYCLES=16;
  - the rounding constant 32768.
- One sub-module, sht40_shift_mul: start/done handshake, 16x15 unsigned sequential multiplier, 31-bit product. done pulses on the 16th MUL cycle.

Test Plan:
- temp_raw=0x0000, temp_ready rises -> temp_centi=-4500 (0xEE6C), temp_valid one pulse 18 cycles later.
- temp_raw=0xFFFF -> 13000; temp_raw=0x6666 -> 2500.
- rh_raw=0x8000 -> 5650. rh_raw=0x0000 -> 0 with SHT40_RH_CLAMP_EN, -600 without. rh_raw=0xFFFF -> 10000 with, 11900 without.
- temp_ready and rh_ready rise same cycle (0x6666, 0x8000) -> temp_valid first (2500), rh_valid exactly 18 cycles later (5650); busy continuous apart from the IDLE reload cycle.
- Change temp_raw 3 cycles after the edge while converting -> result reflects the latched value. Second temp_ready edge during MUL -> second temp_valid follows.
- Assert rst_n low at MUL cycle 8 -> outputs 0, no valid pulse. Ready held high through reset -> after release, one conversion runs and valid fires 18 cycles later.
